// File: rtl/bp_update_sched.sv
// bp_update_sched: buffers resolved-branch updates from two ports and drains them in program
// order to the branch predictor; BTB invalidates are forwarded and cancel matching queued entries.
module bp_update_sched #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [PC_W-1:0]          in0_pc,
  input  logic [PC_W-1:0]          in0_target,
  input  logic                     in0_taken,
  input  logic [1:0]               in0_br_type,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [PC_W-1:0]          in1_pc,
  input  logic [PC_W-1:0]          in1_target,
  input  logic                     in1_taken,
  input  logic [1:0]               in1_br_type,
  input  logic                     hold,
  input  logic                     inv_req,
  input  logic [PC_W-1:0]          inv_pc,
  output logic                     upd_new_entry,
  output logic [PC_W-1:0]          upd_pc_orig,
  output logic [PC_W-1:0]          upd_target_pc,
  output logic                     upd_is_taken,
  output logic [1:0]               upd_br_type,
  output logic                     upd_invalidate,
  output logic [PC_W-1:0]          upd_old_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, wr1_ptr;
  logic [CNT_W-1:0] count_q, count_d, free;
  logic [PC_W-1:0]  pc_q    [DEPTH];
  logic [PC_W-1:0]  pc_d    [DEPTH];
  logic [PC_W-1:0]  tgt_q   [DEPTH];
  logic [PC_W-1:0]  tgt_d   [DEPTH];
  logic             taken_q [DEPTH];
  logic             taken_d [DEPTH];
  logic [1:0]       type_q  [DEPTH];
  logic [1:0]       type_d  [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;

  logic             upd_new_entry_q, upd_new_entry_d;
  logic [PC_W-1:0]  upd_pc_orig_q, upd_pc_orig_d;
  logic [PC_W-1:0]  upd_target_pc_q, upd_target_pc_d;
  logic             upd_is_taken_q, upd_is_taken_d;
  logic [1:0]       upd_br_type_q, upd_br_type_d;
  logic             upd_invalidate_q, upd_invalidate_d;
  logic [PC_W-1:0]  upd_old_pc_q, upd_old_pc_d;

  logic push0, push1, pop, head_live;

  // Ready looks only at the registered count, so a full FIFO never accepts on its pop cycle.
  always_comb begin
    free      = CNT_W'(DEPTH) - count_q;
    in0_ready = !rst && (free >= CNT_W'(1));
    in1_ready = !rst && (in0_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));
    push0     = in0_valid && in0_ready;
    push1     = in1_valid && in1_ready;
    pop       = !hold && (count_q != '0);
    head_live = live_q[head_q] && !(inv_req && (pc_q[head_q] == inv_pc));
    wr1_ptr   = push0 ? tail_q + PTR_W'(1) : tail_q;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block infers a latch.
    pc_d             = pc_q;
    tgt_d            = tgt_q;
    taken_d          = taken_q;
    type_d           = type_q;
    live_d           = live_q;
    head_d           = head_q;
    tail_d           = tail_q + PTR_W'(push0) + PTR_W'(push1);
    count_d          = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    upd_new_entry_d  = 1'b0;
    upd_pc_orig_d    = upd_pc_orig_q;
    upd_target_pc_d  = upd_target_pc_q;
    upd_is_taken_d   = upd_is_taken_q;
    upd_br_type_d    = upd_br_type_q;
    upd_invalidate_d = inv_req;
    upd_old_pc_d     = inv_req ? inv_pc : upd_old_pc_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (inv_req && (pc_q[i] == inv_pc)) live_d[i] = 1'b0;
    end

    if (pop) begin
      head_d         = head_q + PTR_W'(1);
      live_d[head_q] = 1'b0;
      if (head_live) begin
        upd_new_entry_d = 1'b1;
        upd_pc_orig_d   = pc_q[head_q];
        upd_target_pc_d = tgt_q[head_q];
        upd_is_taken_d  = taken_q[head_q];
        upd_br_type_d   = type_q[head_q];
      end
    end

    // Entries arriving alongside a matching invalidate are born dead.
    if (push0) begin
      pc_d[tail_q]    = in0_pc;
      tgt_d[tail_q]   = in0_target;
      taken_d[tail_q] = in0_taken;
      type_d[tail_q]  = in0_br_type;
      live_d[tail_q]  = !(inv_req && (in0_pc == inv_pc));
    end
    if (push1) begin
      pc_d[wr1_ptr]    = in1_pc;
      tgt_d[wr1_ptr]   = in1_target;
      taken_d[wr1_ptr] = in1_taken;
      type_d[wr1_ptr]  = in1_br_type;
      live_d[wr1_ptr]  = !(inv_req && (in1_pc == inv_pc));
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      live_q           <= '0;
      upd_new_entry_q  <= 1'b0;
      upd_pc_orig_q    <= '0;
      upd_target_pc_q  <= '0;
      upd_is_taken_q   <= 1'b0;
      upd_br_type_q    <= '0;
      upd_invalidate_q <= 1'b0;
      upd_old_pc_q     <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      live_q           <= live_d;
      upd_new_entry_q  <= upd_new_entry_d;
      upd_pc_orig_q    <= upd_pc_orig_d;
      upd_target_pc_q  <= upd_target_pc_d;
      upd_is_taken_q   <= upd_is_taken_d;
      upd_br_type_q    <= upd_br_type_d;
      upd_invalidate_q <= upd_invalidate_d;
      upd_old_pc_q     <= upd_old_pc_d;
    end
  end

  // NOTE: the payload array is not reset; the live bits and count alone decide what is valid.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    tgt_q   <= tgt_d;
    taken_q <= taken_d;
    type_q  <= type_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(pop && (count_q == '0)));
    end
  end

  assign upd_new_entry  = upd_new_entry_q;
  assign upd_pc_orig    = upd_pc_orig_q;
  assign upd_target_pc  = upd_target_pc_q;
  assign upd_is_taken   = upd_is_taken_q;
  assign upd_br_type    = upd_br_type_q;
  assign upd_invalidate = upd_invalidate_q;
  assign upd_old_pc     = upd_old_pc_q;
  assign occupancy      = count_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: a per-cycle vector table plus hand-written reset sequences.
module tb_bp_update_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready, in0_taken;
  logic [31:0] in0_pc, in0_target;
  logic [1:0]  in0_br_type;
  logic        in1_valid, in1_ready, in1_taken;
  logic [31:0] in1_pc, in1_target;
  logic [1:0]  in1_br_type;
  logic        hold, inv_req;
  logic [31:0] inv_pc;
  logic        upd_new_entry, upd_is_taken, upd_invalidate;
  logic [31:0] upd_pc_orig, upd_target_pc, upd_old_pc;
  logic [1:0]  upd_br_type;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v0;
    logic [31:0] pc0;
    logic        v1;
    logic [31:0] pc1;
    logic        hold;
    logic        inv;
    logic [31:0] ipc;
    logic        r0;
    logic        r1;
    logic        nw;
    logic [31:0] epc;
    logic        einv;
    logic [31:0] eopc;
    logic [2:0]  occ;
  } row_t;

  row_t rows[$];
  row_t r;

  bp_update_sched #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_pc(in0_pc),
    .in0_target(in0_target), .in0_taken(in0_taken), .in0_br_type(in0_br_type),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_pc(in1_pc),
    .in1_target(in1_target), .in1_taken(in1_taken), .in1_br_type(in1_br_type),
    .hold(hold), .inv_req(inv_req), .inv_pc(inv_pc),
    .upd_new_entry(upd_new_entry), .upd_pc_orig(upd_pc_orig),
    .upd_target_pc(upd_target_pc), .upd_is_taken(upd_is_taken),
    .upd_br_type(upd_br_type), .upd_invalidate(upd_invalidate),
    .upd_old_pc(upd_old_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Payload fields are derived from the pc so every strobe can be checked end to end.
  function automatic logic [31:0] f_tgt(input logic [31:0] pc);
    return pc + 32'h100;
  endfunction
  function automatic logic f_taken(input logic [31:0] pc);
    return ~pc[3];
  endfunction
  function automatic logic [1:0] f_type(input logic [31:0] pc);
    return pc[3:2] + 2'd1;
  endfunction

  function automatic row_t mk(input logic v0, input logic [31:0] pc0, input logic v1,
                              input logic [31:0] pc1, input logic h, input logic inv,
                              input logic [31:0] ipc, input logic r0, input logic r1,
                              input logic nw, input logic [31:0] epc, input logic einv,
                              input logic [31:0] eopc, input logic [2:0] occ);
    row_t x;
    x.v0 = v0; x.pc0 = pc0; x.v1 = v1; x.pc1 = pc1; x.hold = h; x.inv = inv; x.ipc = ipc;
    x.r0 = r0; x.r1 = r1; x.nw = nw; x.epc = epc; x.einv = einv; x.eopc = eopc; x.occ = occ;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] pc0, input logic v1,
                       input logic [31:0] pc1, input logic h, input logic inv,
                       input logic [31:0] ipc);
    in0_valid = v0; in0_pc = pc0; in0_target = f_tgt(pc0);
    in0_taken = f_taken(pc0); in0_br_type = f_type(pc0);
    in1_valid = v1; in1_pc = pc1; in1_target = f_tgt(pc1);
    in1_taken = f_taken(pc1); in1_br_type = f_type(pc1);
    hold = h; inv_req = inv; inv_pc = ipc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    // Vector table: inputs for one cycle, ready before the edge, registered outputs after it.
    //              v0 pc0      v1 pc1      h  i  ipc       r0 r1 nw epc       ei eopc      occ
    rows.push_back(mk(1, 32'h100, 0, 0,       0, 0, 0,       1, 1, 0, 32'h0,   0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h100, 0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h100, 0, 0,       0));
    rows.push_back(mk(1, 32'h10,  1, 32'h14,  0, 0, 0,       1, 1, 0, 32'h100, 0, 0,       2));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h10,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h14,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h14,  0, 0,       0));
    rows.push_back(mk(1, 32'h20,  0, 0,       1, 0, 0,       1, 1, 0, 32'h14,  0, 0,       1));
    rows.push_back(mk(1, 32'h24,  0, 0,       1, 0, 0,       1, 1, 0, 32'h14,  0, 0,       2));
    rows.push_back(mk(1, 32'h28,  0, 0,       1, 0, 0,       1, 1, 0, 32'h14,  0, 0,       3));
    rows.push_back(mk(1, 32'h2c,  0, 0,       1, 0, 0,       1, 0, 0, 32'h14,  0, 0,       4));
    rows.push_back(mk(1, 32'h30,  0, 0,       1, 0, 0,       0, 0, 0, 32'h14,  0, 0,       4));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       0, 0, 1, 32'h20,  0, 0,       3));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h24,  0, 0,       2));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h28,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h2c,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h2c,  0, 0,       0));
    rows.push_back(mk(1, 32'h40,  0, 0,       1, 0, 0,       1, 1, 0, 32'h2c,  0, 0,       1));
    rows.push_back(mk(1, 32'h80,  0, 0,       1, 0, 0,       1, 1, 0, 32'h2c,  0, 0,       2));
    rows.push_back(mk(1, 32'h40,  0, 0,       1, 0, 0,       1, 1, 0, 32'h2c,  0, 0,       3));
    rows.push_back(mk(0, 0,       0, 0,       1, 1, 32'h40,  1, 1, 0, 32'h2c,  1, 32'h40,  3));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h2c,  0, 0,       2));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h80,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h80,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h80,  0, 0,       0));
    rows.push_back(mk(1, 32'h60,  0, 0,       0, 1, 32'h60,  1, 1, 0, 32'h80,  1, 32'h60,  1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h80,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h80,  0, 0,       0));
    rows.push_back(mk(0, 0,       1, 32'h50,  0, 0, 0,       1, 1, 0, 32'h80,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 1, 32'h50,  1, 1, 0, 32'h80,  1, 32'h50,  0));
    rows.push_back(mk(1, 32'h70,  1, 32'h74,  0, 1, 32'h74,  1, 1, 0, 32'h80,  1, 32'h74,  2));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'h70,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h70,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 1, 32'h90,  1, 1, 0, 32'h70,  1, 32'h90,  0));
    rows.push_back(mk(0, 0,       0, 0,       0, 1, 32'h94,  1, 1, 0, 32'h70,  1, 32'h94,  0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'h70,  0, 0,       0));
    rows.push_back(mk(1, 32'ha0,  0, 0,       1, 0, 0,       1, 1, 0, 32'h70,  0, 0,       1));
    rows.push_back(mk(1, 32'ha4,  0, 0,       1, 0, 0,       1, 1, 0, 32'h70,  0, 0,       2));
    rows.push_back(mk(1, 32'ha8,  0, 0,       1, 0, 0,       1, 1, 0, 32'h70,  0, 0,       3));
    rows.push_back(mk(1, 32'hac,  1, 32'hb0,  1, 0, 0,       1, 0, 0, 32'h70,  0, 0,       4));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       0, 0, 1, 32'ha0,  0, 0,       3));
    rows.push_back(mk(1, 32'hb4,  0, 0,       0, 0, 0,       1, 0, 1, 32'ha4,  0, 0,       3));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'ha8,  0, 0,       2));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'hac,  0, 0,       1));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 1, 32'hb4,  0, 0,       0));
    rows.push_back(mk(0, 0,       0, 0,       0, 0, 0,       1, 1, 0, 32'hb4,  0, 0,       0));

    // Reset state.
    tick();
    tick();
    check("reset in0_ready", in0_ready, 0);
    check("reset in1_ready", in1_ready, 0);
    check("reset occupancy", occupancy, 0);
    check("reset upd_new_entry", upd_new_entry, 0);
    check("reset upd_invalidate", upd_invalidate, 0);
    check("reset upd_pc_orig", upd_pc_orig, 0);
    rst = 1'b0;

    for (int i = 0; i < rows.size(); i++) begin
      r = rows[i];
      drive(r.v0, r.pc0, r.v1, r.pc1, r.hold, r.inv, r.ipc);
      #1;
      check($sformatf("row%0d in0_ready", i), in0_ready, r.r0);
      check($sformatf("row%0d in1_ready", i), in1_ready, r.r1);
      tick();
      check($sformatf("row%0d upd_new_entry", i), upd_new_entry, r.nw);
      check($sformatf("row%0d upd_pc_orig", i), upd_pc_orig, r.epc);
      check($sformatf("row%0d upd_invalidate", i), upd_invalidate, r.einv);
      check($sformatf("row%0d occupancy", i), occupancy, r.occ);
      if (r.einv) check($sformatf("row%0d upd_old_pc", i), upd_old_pc, r.eopc);
      if (r.nw) begin
        check($sformatf("row%0d upd_target_pc", i), upd_target_pc, f_tgt(r.epc));
        check($sformatf("row%0d upd_is_taken", i), upd_is_taken, f_taken(r.epc));
        check($sformatf("row%0d upd_br_type", i), upd_br_type, f_type(r.epc));
      end
    end

    // Mid-operation reset discards three queued entries and suppresses the next cycle's strobes.
    drive(1, 32'hc0, 0, 0, 1, 0, 0); tick();
    drive(1, 32'hc4, 0, 0, 1, 0, 0); tick();
    drive(1, 32'hc8, 0, 0, 1, 0, 0); tick();
    check("pre-reset occupancy", occupancy, 3);
    rst = 1'b1;
    drive(1, 32'hcc, 1, 32'hd0, 0, 1, 32'hc0);
    #1;
    check("in-reset in0_ready", in0_ready, 0);
    check("in-reset in1_ready", in1_ready, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post-reset occupancy", occupancy, 0);
    check("post-reset upd_new_entry", upd_new_entry, 0);
    check("post-reset upd_invalidate", upd_invalidate, 0);
    check("post-reset upd_pc_orig", upd_pc_orig, 0);
    check("post-reset upd_target_pc", upd_target_pc, 0);
    check("post-reset upd_old_pc", upd_old_pc, 0);
    check("post-reset in0_ready", in0_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post-reset drain%0d upd_new_entry", i), upd_new_entry, 0);
      check($sformatf("post-reset drain%0d occupancy", i), occupancy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
